// File: rtl/tc_out_pulse_pio.sv
// Avalon-MM parallel output port with DATA/SET/CLR access and an optional timed pulse engine.
// The pulse engine and its PULSE, PULSE_LEN and STATUS registers exist only when TC_OUT_PULSE_EN is defined.
module tc_out_pulse_pio #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      LEN_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] cpu_d;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wmask     = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign out_port  = out_q;

  // Effect of a plain CPU write on the output register, ignoring the pulse engine.
  always_comb begin
    cpu_d = out_q;
    if (wr) begin
      case (address)
        A_DATA:  cpu_d = wmask;
        A_SET:   cpu_d = out_q | wmask;
        A_CLR:   cpu_d = out_q & ~wmask;
        default: cpu_d = out_q;
      endcase
    end
  end

`ifdef TC_OUT_PULSE_EN
  // state   | meaning
  // S_IDLE  | no pulse running, PULSE writes with a nonzero mask start one
  // S_PULSE | latched mask bits held high, counter runs down to expiry
  typedef enum logic {S_IDLE, S_PULSE} state_t;

  localparam logic [2:0] A_PULSE  = 3'd1;
  localparam logic [2:0] A_LEN    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] mask_q;
  logic             busy_q;
  logic [LEN_W-1:0] load_val;

  // A programmed length of 0 behaves as 1, so both load a zero count.
  assign load_val = (len_q == '0) ? '0 : len_q - LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      out_q   <= RESET_VALUE;
      len_q   <= LEN_W'(1);
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      out_q <= cpu_d;
      if (wr && address == A_LEN) len_q <= writedata[LEN_W-1:0];
      case (state_q)
        S_IDLE: begin
          if (wr && address == A_PULSE && wmask != '0) begin
            out_q   <= out_q | wmask;
            mask_q  <= wmask;
            cnt_q   <= load_val;
            state_q <= S_PULSE;
            busy_q  <= 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - LEN_W'(1);
          end else begin
            // Expiry clear overrides any coincident CPU write on the latched bits.
            out_q   <= cpu_d & ~mask_q;
            mask_q  <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0] = out_q;
      A_LEN:    readdata[LEN_W-1:0] = len_q;
      A_STATUS: readdata[0]         = busy_q;
      default:  readdata = '0;
    endcase
  end

  assign busy = busy_q;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= RESET_VALUE;
    else          out_q <= cpu_d;
  end

  always_comb begin
    readdata = '0;
    if (address == A_DATA) readdata[WIDTH-1:0] = out_q;
  end

  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_tc_out_pulse_pio.sv
// Self-checking bench for tc_out_pulse_pio: directed cases plus random bus traffic against a
// cycle-count reference model (pulse end computed as start edge + length).
module tb_tc_out_pulse_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] m_out;
  logic [3:0] m_len;
  logic [3:0] m_mask;
  bit         m_puls;
  longint     m_edge = 0;
  longint     m_end = 0;

  tc_out_pulse_pio #(.WIDTH(4), .LEN_W(4), .RESET_VALUE(4'hA)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 4'hA; m_len = 4'd1; m_mask = 4'd0; m_puls = 1'b0;
  endtask

  task automatic model_edge(input bit wr, input logic [2:0] a, input logic [31:0] d);
    logic [3:0] m;
    logic [3:0] nxt;
    m = d[3:0];
    nxt = m_out;
    m_edge++;
    if (wr) begin
      case (a)
        3'd0: nxt = m;
        3'd4: nxt = m_out | m;
        3'd5: nxt = m_out & ~m;
        default: ;
      endcase
    end
`ifdef TC_OUT_PULSE_EN
    if (m_puls && m_edge == m_end) begin
      nxt &= ~m_mask;
      m_puls = 1'b0;
    end else if (!m_puls && wr && a == 3'd1 && m != 4'd0) begin
      nxt = m_out | m;
      m_mask = m;
      m_puls = 1'b1;
      m_end = m_edge + ((m_len == 4'd0) ? 1 : longint'(m_len));
    end
    if (wr && a == 3'd2) m_len = d[3:0];
`endif
    m_out = nxt;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] ra);
    case (ra)
      3'd0: return {28'd0, m_out};
`ifdef TC_OUT_PULSE_EN
      3'd2: return {28'd0, m_len};
      3'd3: return {31'd0, m_puls};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock of bus activity, then compare outputs and a read of address ra.
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] d, input logic [2:0] ra);
    address = a; chipselect = wr; write_n = !wr; writedata = d;
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = ra;
    #1;
    check("out_port", {28'd0, out_port}, {28'd0, m_out});
    check("busy", {31'd0, busy}, {31'd0, m_puls});
    check("readdata", readdata, m_read(ra));
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_out", {28'd0, out_port}, 32'hA);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_out", {28'd0, out_port}, 32'hA);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    #1;

    step(1, 3'd0, 32'h5, 3'd0);
    check("data_wr", {28'd0, out_port}, 32'h5);
    check("data_rd", readdata, 32'h5);
    step(1, 3'd0, 32'h1, 3'd0);
    step(1, 3'd4, 32'h6, 3'd0);
    check("set", {28'd0, out_port}, 32'h7);
    step(1, 3'd5, 32'h3, 3'd0);
    check("clr", {28'd0, out_port}, 32'h4);

`ifdef TC_OUT_PULSE_EN
    step(1, 3'd0, 32'h0, 3'd2);
    check("len_rst", readdata, 32'h1);
    step(1, 3'd2, 32'h3, 3'd2);
    check("len_rd", readdata, 32'h3);
    step(1, 3'd1, 32'h8, 3'd3);
    check("p3_c1", {27'd0, busy, out_port}, 32'h18);
    check("status1", readdata, 32'h1);
    step(0, 3'd0, 32'h0, 3'd3);
    check("p3_c2", {27'd0, busy, out_port}, 32'h18);
    step(1, 3'd1, 32'h1, 3'd3);
    check("p3_ignored", {27'd0, busy, out_port}, 32'h18);
    step(0, 3'd0, 32'h0, 3'd3);
    check("p3_end", {27'd0, busy, out_port}, 32'h00);
    check("status0", readdata, 32'h0);

    step(1, 3'd2, 32'h0, 3'd0);
    step(1, 3'd1, 32'h2, 3'd0);
    check("p0_c1", {27'd0, busy, out_port}, 32'h12);
    step(0, 3'd0, 32'h0, 3'd0);
    check("p0_end", {27'd0, busy, out_port}, 32'h00);
    step(1, 3'd1, 32'h0, 3'd3);
    check("pulse_zero", {31'd0, busy}, 32'd0);

    step(1, 3'd2, 32'h1, 3'd0);
    step(1, 3'd1, 32'h1, 3'd0);
    step(1, 3'd4, 32'hF, 3'd0);
    check("coincide", {27'd0, busy, out_port}, 32'h0E);

    step(1, 3'd2, 32'hF, 3'd0);
    step(1, 3'd0, 32'h0, 3'd0);
    step(1, 3'd1, 32'h4, 3'd0);
    for (int i = 0; i < 14; i++) begin
      step(0, 3'd0, 32'h0, 3'd3);
      if (i == 13) check("maxlen_last", {27'd0, busy, out_port}, 32'h14);
    end
    step(0, 3'd0, 32'h0, 3'd3);
    check("maxlen_end", {27'd0, busy, out_port}, 32'h00);

    step(1, 3'd2, 32'h5, 3'd0);
    step(1, 3'd1, 32'h3, 3'd0);
    step(1, 3'd2, 32'h1, 3'd0);
    check("len_during", {31'd0, busy}, 32'd1);
    async_reset();
`else
    step(1, 3'd2, 32'h7, 3'd0);
    step(1, 3'd1, 32'hF, 3'd0);
    check("nopulse_out", {28'd0, out_port}, 32'h4);
    check("nopulse_busy", {31'd0, busy}, 32'd0);
    for (int r = 1; r <= 3; r++) begin
      step(0, 3'd0, 32'h0, 3'(r));
      check("nopulse_rd", readdata, 32'd0);
    end
`endif

    for (int i = 0; i < 600; i++) begin
      bit          wr;
      logic [2:0]  a;
      logic [31:0] d;
      wr = ($urandom_range(0, 3) != 0);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      step(wr, a, d, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_out_pulse_pio.md
TC_OUT_PULSE_PIO -- requirements
Module: tc_out_pulse_pio

Interface
REQ-001 Parameter WIDTH, default 4, output channel count; legal 1..32.
REQ-002 Parameter LEN_W, default 16, pulse-length register width; legal 1..32.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into the output register at reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, combinational from address, zero wait states, unused bits 0.
REQ-011 out_port  output  WIDTH  output register value.
REQ-012 busy  output  1  high while a timed pulse is running.

Function
REQ-013 Register map SHALL be: 0 DATA (R/W), 1 PULSE (W), 2 PULSE_LEN (R/W), 3 STATUS (R), 4 SET (W), 5 CLR (W), 6-7 reserved.
REQ-014 A DATA write SHALL load out_port with writedata[WIDTH-1:0] on the next edge; a DATA read SHALL return out_port.
REQ-015 A SET write SHALL OR writedata[WIDTH-1:0] into out_port; a CLR write SHALL clear the bits set in writedata[WIDTH-1:0].
REQ-016 Reads of addresses 1, 4, 5, 6 and 7 SHALL return 0; writes to addresses 3, 6 and 7 SHALL be ignored.
REQ-017 PULSE_LEN SHALL store writedata[LEN_W-1:0]; the effective length L SHALL be PULSE_LEN, with 0 treated as 1.
REQ-018 The pulse engine SHALL have two states, IDLE and PULSE; busy=1 exactly in PULSE.
REQ-019 In IDLE, a PULSE write with a nonzero mask M=writedata[WIDTH-1:0] SHALL set out_port|=M, latch M, load the down-counter with L-1 and enter PULSE on that edge.
REQ-020 In PULSE, on each edge where the counter is nonzero the counter SHALL decrement; where it is zero the engine SHALL clear the latched M bits from out_port and return to IDLE.
REQ-021 Masked bits SHALL therefore be high for exactly L clk cycles after the write edge, and busy SHALL be high for the same L cycles.
REQ-022 A PULSE write with M=0, or any PULSE write while in PULSE, SHALL be ignored.
REQ-023 A PULSE_LEN write during PULSE SHALL NOT alter the running pulse; it SHALL apply to the next pulse.
REQ-024 DATA/SET/CLR writes during PULSE SHALL take effect normally, including on pulsing bits; the expiry clear SHALL still clear the latched M bits.
REQ-025 When a CPU write and pulse expiry coincide, the expiry clear SHALL win for the latched M bits, and the CPU write SHALL decide every other bit.
REQ-026 STATUS SHALL read {31'b0, busy}.
REQ-027 Counter width SHALL be LEN_W; a PULSE_LEN value of 2^LEN_W-1 SHALL produce a pulse of exactly that many cycles, with no wrap.

Reset
REQ-028 Asserting reset_n low SHALL immediately set out_port=RESET_VALUE, PULSE_LEN=1, counter=0, latched mask=0, state=IDLE and busy=0, including mid-pulse.
REQ-029 After reset deasserts, the first clk edge SHALL accept bus writes.

Configuration
REQ-030 When macro TC_OUT_PULSE_EN is defined, the pulse engine, PULSE, PULSE_LEN and STATUS SHALL be implemented as specified.
REQ-031 When TC_OUT_PULSE_EN is undefined, no counter or FSM SHALL be built, addresses 1-3 SHALL read 0 and ignore writes, busy SHALL be tied 0, and DATA/SET/CLR SHALL be unchanged.

Verification
REQ-032 Reset with RESET_VALUE=4'hA, then write DATA=4'h5 -> out_port 4'hA during reset, 4'h5 one edge after the write, read DATA=5.
REQ-033 With out_port=4'h1, write SET=4'h6 then CLR=4'h3 -> out_port 4'h7, then 4'h4.
REQ-034 Write PULSE_LEN=3, then PULSE=4'h8 -> bit3 and busy high for exactly 3 cycles; a second PULSE write mid-pulse has no effect; STATUS reads 1, then 0.
REQ-035 Write PULSE_LEN=0, then PULSE=4'h2 -> bit1 high for exactly 1 cycle; PULSE=0 leaves busy 0.
REQ-036 Issue SET=4'hF on the expiry edge of a PULSE=4'h1 pulse -> out_port=4'hE; assert reset_n mid-pulse -> busy and out_port return to reset values immediately.
REQ-037 Build without TC_OUT_PULSE_EN, write PULSE=4'hF -> out_port unchanged, busy 0, reads of addresses 1-3 return 0.
